// File: rtl/div_seq_ctrl.sv
// Sequential 32-bit restoring divider: one shift-subtract iteration per clock,
// signed/unsigned operands, divide-by-zero and overflow flags, start/busy/done handshake.
module div_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        sign,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] residue,
    output logic        Z,
    output logic        N,
    output logic        C,
    output logic        V
);

    typedef enum logic [2:0] {IDLE, SETUP, RUN, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic [31:0] a_r, b_r;
    logic        sign_r;
    logic [31:0] mag_a;
    logic [31:0] rem;
    logic [31:0] wq;
    logic [5:0]  cnt;
    logic        q_neg, r_neg;
    logic [32:0] rem_sh, diff;
    logic        ge;
    logic [31:0] q_fix, r_fix;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] x, input logic s);
        return (s && x[31]) ? neg32(x) : x;
    endfunction

    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == SETUP) || (state == RUN) || (state == FIX);
    assign done   = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETUP;
            SETUP:   state_nxt = (a_r == 32'd0) ? DONE : RUN;
            RUN:     if (cnt == 6'd31) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = start ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The stored remainder is always below |A|, so the 33-bit shifted value minus |A|
    // borrows out of bit 32 exactly when the trial subtraction must be undone.
    always_comb begin
        rem_sh = {rem, wq[31]};
        diff   = rem_sh - {1'b0, mag_a};
        ge     = ~diff[32];
        q_fix  = q_neg ? neg32(wq) : wq;
        r_fix  = r_neg ? neg32(rem) : rem;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_r      <= '0;
            b_r      <= '0;
            sign_r   <= 1'b0;
            mag_a    <= '0;
            rem      <= '0;
            wq       <= '0;
            cnt      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            quotient <= '0;
            residue  <= '0;
            Z        <= 1'b0;
            N        <= 1'b0;
            C        <= 1'b0;
            V        <= 1'b0;
        end else begin
            if (accept) begin
                a_r    <= A;
                b_r    <= B;
                sign_r <= sign;
            end
            case (state)
                SETUP: begin
                    if (a_r == 32'd0) begin
                        quotient <= 32'hFFFF_FFFF;
                        residue  <= b_r;
                        Z        <= 1'b0;
                        N        <= 1'b1;
                        C        <= 1'b0;
                        V        <= 1'b1;
                    end else begin
                        mag_a <= mag32(a_r, sign_r);
                        wq    <= mag32(b_r, sign_r);
                        rem   <= '0;
                        cnt   <= '0;
                        q_neg <= sign_r & (a_r[31] ^ b_r[31]);
                        r_neg <= sign_r & b_r[31];
                    end
                end
                RUN: begin
                    rem <= ge ? diff[31:0] : rem_sh[31:0];
                    wq  <= {wq[30:0], ge};
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    quotient <= q_fix;
                    residue  <= r_fix;
                    Z        <= (q_fix == 32'd0);
                    N        <= q_fix[31];
                    C        <= 1'b0;
                    V        <= sign_r & (b_r == 32'h8000_0000) & (a_r == 32'hFFFF_FFFF);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: stimulus pushes model results, a monitor checks each done.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        sign = 1'b0;
    logic        busy, done;
    logic [31:0] quotient, residue;
    logic        Z, N, C, V;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z, n, c, v;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    div_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .sign(sign),
        .busy(busy), .done(done), .quotient(quotient), .residue(residue),
        .Z(Z), .N(N), .C(C), .V(V)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer division semantics, with the two special cases handled up front.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input int c);
        exp_t e;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        e.c = 1'b0;
        if (a == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = b; e.v = 1'b1; e.z = 1'b0; e.n = 1'b1;
            e.cyc = c + 2;
            return e;
        end
        if (s && b == 32'h8000_0000 && a == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000; e.r = 32'd0; e.v = 1'b1;
        end else if (s) begin
            e.q = sb / sa; e.r = sb % sa; e.v = 1'b0;
        end else begin
            e.q = b / a; e.r = b % a; e.v = 1'b0;
        end
        e.z = (e.q == 32'd0);
        e.n = e.q[31];
        e.cyc = c + 35;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic want);
        chk(nm, {31'd0, act}, {31'd0, want});
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("quotient", quotient, mon_e.q);
                chk("residue", residue, mon_e.r);
                chk1("Z", Z, mon_e.z);
                chk1("N", N, mon_e.n);
                chk1("C", C, mon_e.c);
                chk1("V", V, mon_e.v);
                chk("done_cycle", cyc, mon_e.cyc);
                chk1("busy_with_done", busy, 1'b0);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(posedge clk); #1;
        A = a; B = b; sign = s; start = 1'b1;
        exp_q.push_back(model(a, b, s, cyc));
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; B = $urandom; sign = $urandom_range(0, 1);
    endtask

    task automatic wait_done(input int want_busy);
        int n = 0;
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            else if (busy) n++;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
        chk("busy_cycles", n, want_busy);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    logic [31:0] ra, rb;

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_residue", residue, 32'd0);
        chk1("rst_Z", Z, 1'b0);
        chk1("rst_N", N, 1'b0);
        chk1("rst_C", C, 1'b0);
        chk1("rst_V", V, 1'b0);

        // Directed cases, each with a busy-length check
        issue(32'd5, 32'd15, 1'b0);                  wait_done(34);
        issue(32'd2, 32'hFFFF_FFF9, 1'b1);           wait_done(34);
        issue(32'hFFFF_FFFE, 32'd7, 1'b1);           wait_done(34);
        issue(32'd0, 32'd123, 1'b1);                 wait_done(1);
        issue(32'hFFFF_FFFF, 32'h8000_0000, 1'b1);   wait_done(34);
        issue(32'hFFFF_FFFF, 32'h8000_0000, 1'b0);   wait_done(34);

        // start pulsed during RUN with other operands must be ignored
        issue(32'd7, 32'd100, 1'b0);
        repeat (4) @(posedge clk);
        #1 A = 32'd3; B = 32'd9; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        drain();

        // start held through DONE: second request accepted back-to-back
        @(posedge clk); #1;
        A = 32'd9; B = 32'd1000; sign = 1'b0; start = 1'b1;
        exp_q.push_back(model(32'd9, 32'd1000, 1'b0, cyc));
        exp_q.push_back(model(32'hFFFF_FFFD, 32'd50, 1'b1, cyc + 35));
        @(posedge clk); #1;
        A = 32'hFFFF_FFFD; B = 32'd50; sign = 1'b1;
        repeat (35) @(posedge clk);
        #1 start = 1'b0;
        drain();

        // reset mid-RUN drops the request
        issue(32'd11, 32'd12345, 1'b0);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_done", done, 1'b0);
        chk("mid_rst_quotient", quotient, 32'd0);
        chk("mid_rst_residue", residue, 32'd0);
        chk1("mid_rst_V", V, 1'b0);
        chk1("mid_rst_N", N, 1'b0);
        repeat (40) @(negedge clk);
        issue(32'd3, 32'd10, 1'b0);
        drain();

        // Randomized operands with edge values mixed in
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 4))
                0:       ra = 32'd0;
                1:       ra = 32'hFFFF_FFFF;
                2:       ra = $urandom_range(1, 20);
                3:       ra = $urandom & 32'h0000_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       rb = 32'h8000_0000;
                1:       rb = $urandom_range(0, 1000);
                default: rb = $urandom;
            endcase
            issue(ra, rb, 1'($urandom_range(0, 1)));
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Multi-cycle sequencer for the ALU's integer divide path. It captures one divide request and computes quotient and residue with a 32-iteration restoring shift-subtract loop, one iteration per clock. It handles signed and unsigned operands, divide-by-zero and signed overflow, and presents registered results and Z/N/C/V flags with a start/busy/done handshake. It sits between the ALU operation decoder and the register write-back stage, and replaces the combinational divide for timing closure.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  single clock, rising-edge.
- reset  in  1  synchronous, active-high; one clock is sufficient.
- start  in  1  request; sampled only in IDLE or DONE.
- A  in  32  divisor, captured on accept.
- B  in  32  dividend, captured on accept.
- sign  in  1  1 = two's-complement operands, 0 = unsigned; captured on accept.
- busy  out  1  high while a request is in progress (SETUP, RUN, FIX).
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- quotient  out  32  registered quotient.
- residue  out  32  registered remainder.
- Z  out  1  zero flag.
- N  out  1  negative flag.
- C  out  1  carry flag.
- V  out  1  overflow flag.

## Operation
- States: IDLE, SETUP, RUN, FIX, DONE.
- IDLE/DONE with start=1: latch A, B, sign, then go to SETUP. Otherwise DONE goes to IDLE and IDLE holds.
- SETUP, divisor A==0: quotient=32'hFFFF_FFFF, residue=B (raw), V=1, Z=0, N=1, C=0, then go to DONE.
- SETUP, A!=0: form magnitudes (|A|, |B| when sign=1 and the operand MSB is set, else raw). Record q_neg = sign & (A[31]^B[31]) and r_neg = sign & B[31]. Clear the 33-bit partial remainder and the iteration counter, load the working quotient with |B|, then go to RUN.
- RUN, each cycle:
  - rem = {rem[31:0], wq[31]}; wq = wq<<1.
  - If rem >= {1'b0,|A|}: rem -= |A| and wq[0]=1.
  - Counter increments. After the 32nd iteration, go to FIX.
- FIX:
  - quotient = q_neg ? -wq : wq.
  - residue = r_neg ? -rem[31:0] : rem[31:0].
  - Division truncates toward zero; the remainder takes the sign of the dividend.
  - Go to DONE.
- Flags, written in FIX:
  - Z = (quotient==0).
  - N = quotient[31].
  - C = 0.
  - V = sign & (B==32'h8000_0000) & (A==32'hFFFF_FFFF). In that case quotient=32'h8000_0000 and residue=0, the natural result.
- Outputs quotient, residue and the flags hold their values until the next request writes them (SETUP for divide-by-zero, FIX otherwise). A new start does not clear them.
- start in SETUP/RUN/FIX is ignored, not queued. Operand inputs are don't-care outside the accept cycle.
- Reset in any state, including mid-RUN, forces IDLE and clears all internal state. The request in flight is dropped and produces no done.

## Timing
- Reset values: busy=0, done=0, quotient=0, residue=0, Z=0, N=0, C=0, V=0; state IDLE.
- Accept at cycle t, counting each cycle by the state it is in:
  - SETUP at t+1.
  - RUN at t+2..t+33.
  - FIX at t+34.
  - DONE at t+35.
- done is high during t+35 only. The result registers are valid at t+35 and stay valid after it.
- busy is high t+1..t+34 and low in DONE. Back-to-back: a start during DONE (t+35) is accepted, so throughput is one divide per 35 cycles.
- Divide-by-zero: SETUP at t+1, DONE/done at t+2, busy high only at t+1.
- busy and done are registered state decodes and are never high together.

## Test plan
- Unsigned: A=5, B=15, sign=0, start at t -> done at t+35, quotient=3, residue=0, Z=0, N=0, C=0, V=0. busy=1 exactly t+1..t+34.
- Signed truncation: A=2, B=-7 (32'hFFFF_FFF9), sign=1 -> quotient=32'hFFFF_FFFD, residue=32'hFFFF_FFFF, N=1. Then A=-2, B=7 -> quotient=32'hFFFF_FFFD, residue=1.
- Divide-by-zero: A=0, B=123, sign=1 -> done at t+2, quotient=32'hFFFF_FFFF, residue=123, V=1, N=1.
- Overflow and edges:
  - A=32'hFFFF_FFFF, B=32'h8000_0000, sign=1 -> quotient=32'h8000_0000, residue=0, V=1.
  - Same operands with sign=0 -> quotient=0, residue=32'h8000_0000, Z=1, V=0.
- Handshake: start pulsed again during RUN with different operands -> ignored, first result delivered at t+35. A start held high during DONE -> second request accepted, second done at t+70.
- Reset mid-operation: reset at t+10 -> IDLE next cycle, all outputs 0, no done pulse. A fresh request A=3, B=10, sign=0 then completes with quotient=3, residue=1.
